// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind a req/ack handshake, fixed LATENCY wait cycles per access, one-cycle ack.
// busy_o stalls the pipeline from request through WAIT; define DMEM_MISALIGN_CHECK_EN to flag/suppress misaligned accesses on err_o.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        busy_o
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    output logic        err_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            mis_q;
    logic            mis_now;
    logic            accept;
    logic            complete;
    logic            do_write;
    logic            do_read;
    logic            unused_addr;
    logic [31:0]     mem [DEPTH];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign mis_now     = |addr_i[1:0];
    assign unused_addr = ^addr_i[31:AW+2];
    assign err_o       = (state == RESP) && mis_q;
`else
    assign mis_now     = 1'b0;
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
`endif

    assign accept   = (state == IDLE) && req_i;
    // The access itself happens on the WAIT->RESP edge, so a reset in WAIT aborts it cleanly.
    assign complete = (state == WAIT) && (cnt == 4'd0);
    assign do_write = complete && we_q && !mis_q;
    assign do_read  = complete && !we_q && !mis_q;

    assign ack_o  = (state == RESP);
    assign busy_o = accept || (state == WAIT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_i) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            mis_q   <= 1'b0;
        end else if (accept) begin
            cnt     <= 4'(LATENCY - 1);
            we_q    <= we_i;
            idx_q   <= addr_i[AW+1:2];
            wdata_q <= wdata_i;
            mis_q   <= mis_now;
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_o <= 32'd0;
        end else if (do_read) begin
            rdata_o <= mem[idx_q];
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for function/stall/reset, LATENCY=1 instance for back-to-back timing.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic        ack, busy;
    logic [31:0] rdata;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic        ack1, busy1;
    logic [31:0] rdata1;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        err, err1;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack), .rdata_o(rdata), .busy_o(busy)
`ifdef DMEM_MISALIGN_CHECK_EN
        , .err_o(err)
`endif
    );

    dmem_responder #(.DEPTH(16), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
        .ack_o(ack1), .rdata_o(rdata1), .busy_o(busy1)
`ifdef DMEM_MISALIGN_CHECK_EN
        , .err_o(err1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the request cycle; inputs are scrambled once the request is accepted.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int cyc, output logic [31:0] rd, output logic stall_ok,
                          output logic extra, output logic e);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        #1 stall_ok = (busy === 1'b1);
        cyc = 0; rd = 32'd0; e = 1'b0; extra = 1'b0;
        @(posedge clk); #1;
        we = ~w; addr = ~a; wdata = ~d;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ack === 1'b1) break;
            if (busy !== 1'b1) stall_ok = 1'b0;
        end
        rd = rdata;
        if (busy !== 1'b0) stall_ok = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        e = err;
`endif
        req = 1'b0;
        @(negedge clk);
        extra = ack;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          cyc;
        logic [31:0] rd;
        logic        sok, ex, e;
        int          c, a1st, a2nd;

        rst_i = 1'b0;
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        #1;
        chk("reset_ack", {31'd0, ack}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("reset_err", {31'd0, err}, 32'd0);
`endif
        @(negedge clk); @(negedge clk);
        rst_i = 1'b1;

        access(1'b1, 32'h10, 32'hDEADBEEF, cyc, rd, sok, ex, e);
        chk("wr10_ack_cycle", cyc, 32'd3);
        chk("wr10_stall", {31'd0, sok}, 32'd1);
        chk("wr10_single_ack", {31'd0, ex}, 32'd0);
        chk("wr10_rdata_unchanged", rd, 32'd0);

        access(1'b0, 32'h10, 32'h0, cyc, rd, sok, ex, e);
        chk("rd10_ack_cycle", cyc, 32'd3);
        chk("rd10_data", rd, 32'hDEADBEEF);
        chk("rd10_stall", {31'd0, sok}, 32'd1);
        chk("rd10_single_ack", {31'd0, ex}, 32'd0);
        chk("rd10_rdata_held", rdata, 32'hDEADBEEF);

        access(1'b1, 32'h4, 32'h1, cyc, rd, sok, ex, e);
        chk("wr4_rdata_unchanged", rd, 32'hDEADBEEF);
        access(1'b0, 32'h404, 32'h0, cyc, rd, sok, ex, e);
        chk("wrap_rd404", rd, 32'h1);

        access(1'b1, 32'h20, 32'h11, cyc, rd, sok, ex, e);
        chk("wr20_ack_cycle", cyc, 32'd3);

        // Reset in WAIT: the pending write of 0x55 must be dropped.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55;
        @(posedge clk); #2;
        rst_i = 1'b0; req = 1'b0;
        #1;
        chk("midwait_rst_ack", {31'd0, ack}, 32'd0);
        chk("midwait_rst_rdata", rdata, 32'd0);
        chk("midwait_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_i = 1'b1;

        access(1'b0, 32'h20, 32'h0, cyc, rd, sok, ex, e);
        chk("post_rst_ack_cycle", cyc, 32'd3);
        chk("post_rst_rd20", rd, 32'h11);
        access(1'b0, 32'h10, 32'h0, cyc, rd, sok, ex, e);
        chk("post_rst_rd10", rd, 32'hDEADBEEF);

`ifdef DMEM_MISALIGN_CHECK_EN
        access(1'b1, 32'h13, 32'h7, cyc, rd, sok, ex, e);
        chk("mis_wr13_err", {31'd0, e}, 32'd1);
        chk("mis_wr13_ack_cycle", cyc, 32'd3);
        chk("mis_err_after_resp", {31'd0, err}, 32'd0);
        access(1'b0, 32'h10, 32'h0, cyc, rd, sok, ex, e);
        chk("mis_word10_kept", rd, 32'hDEADBEEF);
        chk("aligned_rd_err", {31'd0, e}, 32'd0);
        access(1'b0, 32'h4, 32'h0, cyc, rd, sok, ex, e);
        access(1'b0, 32'h11, 32'h0, cyc, rd, sok, ex, e);
        chk("mis_rd_err", {31'd0, e}, 32'd1);
        chk("mis_rd_rdata_kept", rd, 32'h1);
`else
        access(1'b1, 32'h13, 32'h7, cyc, rd, sok, ex, e);
        access(1'b0, 32'h10, 32'h0, cyc, rd, sok, ex, e);
        chk("lowbits_ignored_rd10", rd, 32'h7);
`endif

        // LATENCY=1 instance, two reads with req held continuously.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
        c = 0; a1st = -1; a2nd = -1;
        while (c < 12 && a2nd < 0) begin
            @(negedge clk);
            c++;
            if (ack1 === 1'b1) begin
                if (a1st < 0) a1st = c;
                else a2nd = c;
            end
        end
        req1 = 1'b0;
        chk("b2b_first_ack", a1st, 32'd2);
        chk("b2b_second_ack", a2nd, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
